mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared multicycle control encodings.
// Opcodes, FSM states, datapath mux/ALU selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI) ||
           (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle CPU control FSM with retire counter.
// In: clk, resetn, op[5:0], zero, mem_ready.
// Out: mem_req, mem_wr, iord, irwrite, pcwrite, pcsrc[1:0],
//   alusrca, alusrcb[1:0], aluop[1:0], regwrite, regdst,
//   memtoreg, retired[31:0].
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic [1:0]  pcsrc,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic [31:0] retired
);

  state_e      r_state;
  state_e      w_next;
  ctrl_t       w_ctrl;
  logic        w_retire;
  logic [31:0] r_retired;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem(op):        w_next = S_MEMADR;
          (op == OP_RTYPE):  w_next = S_EXEC;
          is_imm(op):        w_next = S_IMMEX;
          (op == OP_BEQ):    w_next = S_BRANCH;
          (op == OP_J):      w_next = S_JUMP;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR:
        w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl   = '0;
    w_retire = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.aluop   = ALUOP_ADD;
        w_ctrl.pcsrc   = PCSRC_ALU;
        w_ctrl.irwrite = mem_ready;
        w_ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alusrcb = SRCB_IMMSH;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.iord    = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_wr  = 1'b1;
        w_ctrl.iord    = 1'b1;
        w_retire       = mem_ready;
      end
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_retire        = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_RT;
        w_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regdst   = 1'b1;
        w_retire        = 1'b1;
      end
      S_IMMEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALUOP_OPC;
      end
      S_IMMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_retire        = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_RT;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_ctrl.pcwrite = zero;
        w_retire       = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pcsrc   = PCSRC_JUMP;
        w_ctrl.pcwrite = 1'b1;
        w_retire       = 1'b1;
      end
      default: begin
        w_ctrl   = '0;
        w_retire = 1'b0;
      end
    endcase
  end

  // Counter is only written on a retire so it holds
  // any externally loaded value between instructions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // State is already FETCH during reset; only the
  // mem_ready-qualified enables need masking.
  assign mem_req  = w_ctrl.mem_req;
  assign mem_wr   = w_ctrl.mem_wr;
  assign iord     = w_ctrl.iord;
  assign irwrite  = w_ctrl.irwrite & resetn;
  assign pcwrite  = w_ctrl.pcwrite & resetn;
  assign pcsrc    = w_ctrl.pcsrc;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign aluop    = w_ctrl.aluop;
  assign regwrite = w_ctrl.regwrite;
  assign regdst   = w_ctrl.regdst;
  assign memtoreg = w_ctrl.memtoreg;
  assign retired  = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + random instruction stream
// against a phase-table reference model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  op = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_wr, iord, irwrite, pcwrite;
  logic [1:0]  pcsrc, alusrcb, aluop;
  logic        alusrca, regwrite, regdst, memtoreg;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;

  mc_ctrl dut (
    .clk(clk), .resetn(resetn), .op(op), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_wr(mem_wr), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop),
    .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [14:0] obs = {mem_req, mem_wr, iord, irwrite,
                     pcwrite, pcsrc, alusrca, alusrcb,
                     aluop, regwrite, regdst, memtoreg};

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXEC   = 6;
  localparam int P_ALUWB  = 7;
  localparam int P_IMMEX  = 8;
  localparam int P_IMMWB  = 9;
  localparam int P_BRANCH = 10;
  localparam int P_JUMP   = 11;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_XORI = 6'b001110;
  localparam logic [5:0] T_LUI  = 6'b001111;

  // Expected control word for a phase, straight from the
  // per-state output table; unnamed outputs stay 0.
  function automatic logic [14:0] expv(input int ph,
                                       input logic rdy,
                                       input logic z);
    logic rq, wr, io, ir, pw, sa, rw, rd, mr;
    logic [1:0] ps, sb, ao;
    {rq, wr, io, ir, pw, sa, rw, rd, mr} = '0;
    {ps, sb, ao} = '0;
    case (ph)
      P_FETCH:  begin rq = 1; sb = 2'b01; ir = rdy; pw = rdy; end
      P_DECODE: sb = 2'b11;
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin rq = 1; io = 1; end
      P_MEMWR:  begin rq = 1; io = 1; wr = 1; end
      P_MEMWB:  begin rw = 1; mr = 1; end
      P_EXEC:   begin sa = 1; ao = 2'b10; end
      P_ALUWB:  begin rw = 1; rd = 1; end
      P_IMMEX:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
      P_IMMWB:  rw = 1;
      P_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; end
      P_JUMP:   begin ps = 2'b10; pw = 1; end
      default:  ;
    endcase
    return {rq, wr, io, ir, pw, ps, sa, sb, ao, rw, rd, mr};
  endfunction

  task automatic chk(input string tag, input logic [14:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s ctrl observed %h expected %h",
             tag, obs, e);
    end
    checks++;
    assert (retired === exp_ret) else begin
      errors++;
      $error("FAIL %s retired observed %h expected %h",
             tag, retired, exp_ret);
    end
  endtask

  // One clock in a phase: drive, check, advance.
  task automatic cyc(input int ph, input logic rdy,
                     input logic z, input string tag);
    mem_ready = rdy;
    zero = z;
    #1;
    chk(tag, expv(ph, rdy, z));
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cyc(input int ph, input string tag);
    cyc(ph, 1'($urandom), 1'($urandom), tag);
  endtask

  task automatic mem_ph(input int ph, input int waits,
                        input string tag);
    for (int i = 0; i < waits; i++)
      cyc(ph, 1'b0, 1'($urandom), tag);
    cyc(ph, 1'b1, 1'($urandom), tag);
  endtask

  task automatic run(input logic [5:0] o, input logic z,
                     input int wf, input int wm);
    op = o;
    mem_ph(P_FETCH, wf, "fetch");
    rnd_cyc(P_DECODE, "decode");
    case (o)
      T_LW: begin
        rnd_cyc(P_MEMADR, "lw_adr");
        mem_ph(P_MEMRD, wm, "lw_rd");
        rnd_cyc(P_MEMWB, "lw_wb");
        exp_ret++;
      end
      T_SW: begin
        rnd_cyc(P_MEMADR, "sw_adr");
        mem_ph(P_MEMWR, wm, "sw_wr");
        exp_ret++;
      end
      T_R: begin
        rnd_cyc(P_EXEC, "r_ex");
        rnd_cyc(P_ALUWB, "r_wb");
        exp_ret++;
      end
      T_ADDI, T_ANDI, T_ORI, T_XORI, T_LUI: begin
        rnd_cyc(P_IMMEX, "imm_ex");
        rnd_cyc(P_IMMWB, "imm_wb");
        exp_ret++;
      end
      T_BEQ: begin
        cyc(P_BRANCH, 1'($urandom), z, "beq");
        exp_ret++;
      end
      T_J: begin
        rnd_cyc(P_JUMP, "jump");
        exp_ret++;
      end
      default: ;
    endcase
  endtask

  logic [5:0] legal [10] = '{T_R, T_LW, T_SW, T_BEQ, T_J,
                             T_ADDI, T_ANDI, T_ORI,
                             T_XORI, T_LUI};

  initial begin
    logic [5:0] o;
    // reset state, with mem_ready high to exercise gating
    resetn = 1'b0;
    mem_ready = 1'b1;
    #2;
    checks++;
    assert (obs === expv(P_FETCH, 1'b0, 1'b0)) else begin
      errors++;
      $error("FAIL reset ctrl observed %h expected %h",
             obs, expv(P_FETCH, 1'b0, 1'b0));
    end
    @(posedge clk);
    #1;
    chk("reset_hold", expv(P_FETCH, 1'b0, 1'b0));
    resetn = 1'b1;

    // ADDI, ready always 1
    run(T_ADDI, 1'b0, 0, 0);
    cyc(P_FETCH, 1'b0, 1'b0, "addi_done");

    // LW with 3 wait cycles in MEMRD
    run(T_LW, 1'b0, 0, 3);

    // BEQ not taken then taken
    run(T_BEQ, 1'b0, 0, 0);
    run(T_BEQ, 1'b1, 1, 0);

    // illegal opcode
    run(6'b111111, 1'b0, 0, 0);
    cyc(P_FETCH, 1'b0, 1'b0, "illegal_done");

    // reset mid-write with mem_ready low
    op = T_SW;
    mem_ph(P_FETCH, 0, "rs_fetch");
    rnd_cyc(P_DECODE, "rs_decode");
    rnd_cyc(P_MEMADR, "rs_adr");
    cyc(P_MEMWR, 1'b0, 1'b0, "rs_wr");
    mem_ready = 1'b0;
    resetn = 1'b0;
    exp_ret = '0;
    #1;
    chk("rs_async", expv(P_FETCH, 1'b0, 1'b0));
    mem_ready = 1'b1;
    #1;
    chk("rs_gate", expv(P_FETCH, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run(T_ORI, 1'b0, 2, 0);

    // wrap: preload counter while stalled in FETCH
    cyc(P_FETCH, 1'b0, 1'b0, "pre_stall");
    mem_ready = 1'b0;
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    exp_ret = 32'hFFFF_FFFF;
    run(T_J, 1'b0, 1, 0);
    cyc(P_FETCH, 1'b0, 1'b0, "wrap_done");

    // random instruction stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0)
        o = 6'($urandom);
      else
        o = legal[$urandom_range(0, 9)];
      run(o, 1'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 3));
    end
    cyc(P_FETCH, 1'b0, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
